// File: rtl/keypad_scan_encoder.sv
// -----------------------------------------------------------------------------
// keypad_scan_encoder
//
// Scans a 4x4 active-low matrix keypad and produces a debounced key code
// for the keypad capture logic downstream.
//
// The scan drives one row low at a time. Each row is held for SCAN_DIV
// cycles before its columns are sampled. When exactly one column reads low,
// the scan freezes on that row and the column pattern must stay stable for
// DEBOUNCE_CYC samples before the key is accepted. Only the captured column
// is watched while the key is held. Releasing the key must also stay stable
// for DEBOUNCE_CYC samples before E drops and scanning resumes. The code on
// A..D keeps the last accepted key after E falls.
//
// Ports:
//   CLK    in   system clock
//   RESET  in   synchronous, active-high reset
//   COL_N  in   [3:0] keypad columns, active-low, asynchronous to CLK
//   ROW_N  out  [3:0] row drive, active-low, exactly one bit low at a time
//   A..D   out  key code bits 0..3, code = 4*row + col
//   E      out  data available, high while a debounced key is held
// -----------------------------------------------------------------------------
module keypad_scan_encoder #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CYC = 50000,
    parameter int CNT_W        = 20
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] COL_N,
    output logic [3:0] ROW_N,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       D,
    output logic       E
);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } scanState_t;

    // Terminal counts for the shared counter.
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // -------------------------------------------------------------------------
    // Column synchronizer
    // -------------------------------------------------------------------------
    // Two flops per column. Every decision below reads colS only.
    logic [3:0] colMetaReg;
    logic [3:0] colS;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            colMetaReg <= 4'b1111;
            colS       <= 4'b1111;
        end else begin
            colMetaReg <= COL_N;
            colS       <= colMetaReg;
        end
    end

    // Active-high view of the synchronized columns.
    logic [3:0] colLow;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : gColLow
            assign colLow[gi] = ~colS[gi];
        end
    endgenerate

    // A key is only captured when exactly one column is low. With two or more
    // keys on the same row the column alone cannot identify one key, so that
    // row is skipped.
    logic       singleLow;
    logic [1:0] lowCol;

    always_comb begin
        singleLow = (colLow != 4'b0000) && ((colLow & (colLow - 4'b0001)) == 4'b0000);
        lowCol    = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (colLow[i]) begin
                lowCol = 2'(i);
            end
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    scanState_t       stateReg,  stateNext;
    logic [1:0]       rowIdxReg, rowIdxNext;
    logic [CNT_W-1:0] cntReg,    cntNext;
    logic [3:0]       capPatReg, capPatNext;
    logic [1:0]       capColReg, capColNext;
    logic [3:0]       codeReg,   codeNext;
    logic             eReg,      eNext;
    logic [3:0]       rowNReg;
    logic [3:0]       rowNNext;

    // The row drive is registered. It is decoded from the next row index so
    // that it changes on the same edge as the index.
    generate
        for (gi = 0; gi < 4; gi++) begin : gRowDecode
            assign rowNNext[gi] = (rowIdxNext != 2'(gi));
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RESET) begin
            stateReg  <= SCAN;
            rowIdxReg <= 2'd0;
            rowNReg   <= 4'b1110;
            cntReg    <= '0;
            capPatReg <= 4'b1111;
            capColReg <= 2'd0;
            codeReg   <= 4'd0;
            eReg      <= 1'b0;
        end else begin
            stateReg  <= stateNext;
            rowIdxReg <= rowIdxNext;
            rowNReg   <= rowNNext;
            cntReg    <= cntNext;
            capPatReg <= capPatNext;
            capColReg <= capColNext;
            codeReg   <= codeNext;
            eReg      <= eNext;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        stateNext  = stateReg;
        rowIdxNext = rowIdxReg;
        cntNext    = cntReg;
        capPatNext = capPatReg;
        capColNext = capColReg;
        codeNext   = codeReg;
        eNext      = eReg;

        unique case (stateReg)
            SCAN: begin
                if (cntReg == SCAN_LAST) begin
                    cntNext = '0;
                    if (singleLow) begin
                        // Freeze on this row and remember the whole pattern.
                        // Debounce then requires all four columns to stay
                        // unchanged.
                        stateNext  = DEBOUNCE;
                        capPatNext = colS;
                        capColNext = lowCol;
                    end else begin
                        rowIdxNext = rowIdxReg + 2'd1;
                    end
                end else begin
                    cntNext = cntReg + CNT_ONE;
                end
            end

            DEBOUNCE: begin
                if (colS == capPatReg) begin
                    if (cntReg == DEB_LAST) begin
                        stateNext = PRESSED;
                        cntNext   = '0;
                        codeNext  = {rowIdxReg, capColReg};
                        eNext     = 1'b1;
                    end else begin
                        cntNext = cntReg + CNT_ONE;
                    end
                end else begin
                    // Bounce or glitch. Drop it and continue the scan.
                    stateNext  = SCAN;
                    cntNext    = '0;
                    rowIdxNext = rowIdxReg + 2'd1;
                end
            end

            PRESSED: begin
                // Only the captured column matters here. Other keys pressed
                // on the same row cannot disturb the held code.
                if (colS[capColReg]) begin
                    stateNext = RELEASE;
                    cntNext   = '0;
                end
            end

            RELEASE: begin
                if (colS[capColReg]) begin
                    if (cntReg == DEB_LAST) begin
                        stateNext  = SCAN;
                        cntNext    = '0;
                        eNext      = 1'b0;
                        rowIdxNext = rowIdxReg + 2'd1;
                    end else begin
                        cntNext = cntReg + CNT_ONE;
                    end
                end else begin
                    // The key came back before the release was confirmed.
                    stateNext = PRESSED;
                    cntNext   = '0;
                end
            end

            default: begin
                stateNext = SCAN;
                cntNext   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs (all driven directly from registers)
    // -------------------------------------------------------------------------
    assign ROW_N = rowNReg;
    assign A     = codeReg[0];
    assign B     = codeReg[1];
    assign C     = codeReg[2];
    assign D     = codeReg[3];
    assign E     = eReg;

endmodule

// File: tb/tb_keypad_scan_encoder.sv
// -----------------------------------------------------------------------------
// tb_keypad_scan_encoder
//
// Directed bench for keypad_scan_encoder with SCAN_DIV=4 and DEBOUNCE_CYC=8.
// A matrix model pulls COL_N[c] low when key (r,c) is down and row r is
// driven. A behavioural model predicts ROW_N, E and the code every cycle.
// Literal expectations at key points pin both the model and the DUT.
// -----------------------------------------------------------------------------
module tb_keypad_scan_encoder;

    localparam int SD = 4;
    localparam int DC = 8;

    logic       CLK;
    logic       RESET;
    logic [3:0] COL_N;
    logic [3:0] ROW_N;
    logic       A, B, C, D, E;
    logic [3:0] code;

    logic [15:0] keyDown;   // bit 4*r+c set = key (r,c) held

    int checks = 0;
    int errors = 0;

    keypad_scan_encoder #(
        .SCAN_DIV    (SD),
        .DEBOUNCE_CYC(DC),
        .CNT_W       (8)
    ) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .COL_N(COL_N),
        .ROW_N(ROW_N),
        .A    (A),
        .B    (B),
        .C    (C),
        .D    (D),
        .E    (E)
    );

    assign code = {D, C, B, A};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Keypad matrix: a column reads low if any held key on it sits on a
    // driven (low) row.
    always_comb begin
        COL_N = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keyDown[4*r+c] && (ROW_N[r] == 1'b0)) begin
                    COL_N[c] = 1'b0;
                end
            end
        end
    end

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkInt(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Behavioural model, advanced on every rising edge
    // -------------------------------------------------------------------------
    // Phases: 0 scanning, 1 confirming a press, 2 key held, 3 confirming a
    // release. The model sees COL_N two edges late, as the synchronizer does.
    bit         modelValid = 0;
    int         mPhase, mRow, mCol, mDwell, mRun;
    logic [3:0] mPat, mSeen1, mSeen2;
    logic       mE;
    logic [3:0] mCode;

    always @(posedge CLK) begin
        logic [3:0] seen;
        int         lows;
        int         lowIdx;
        if (RESET) begin
            modelValid = 1;
            mPhase = 0; mRow = 0; mCol = 0; mDwell = 0; mRun = 0;
            mPat = 4'hF; mSeen1 = 4'hF; mSeen2 = 4'hF;
            mE = 1'b0; mCode = 4'd0;
        end else if (modelValid) begin
            seen   = mSeen2;
            mSeen2 = mSeen1;
            mSeen1 = COL_N;
            case (mPhase)
                0: begin
                    mDwell++;
                    if (mDwell == SD) begin
                        mDwell = 0;
                        lows = 0;
                        lowIdx = 0;
                        for (int c = 0; c < 4; c++) begin
                            if (!seen[c]) begin
                                lows++;
                                lowIdx = c;
                            end
                        end
                        if (lows == 1) begin
                            mPhase = 1; mPat = seen; mCol = lowIdx; mRun = 0;
                        end else begin
                            mRow = (mRow + 1) % 4;
                        end
                    end
                end
                1: begin
                    if (seen == mPat) begin
                        mRun++;
                        if (mRun == DC) begin
                            mPhase = 2; mE = 1'b1; mCode = 4'(4 * mRow + mCol);
                        end
                    end else begin
                        mPhase = 0; mDwell = 0; mRow = (mRow + 1) % 4;
                    end
                end
                2: begin
                    if (seen[mCol]) begin
                        mPhase = 3; mRun = 0;
                    end
                end
                default: begin
                    if (seen[mCol]) begin
                        mRun++;
                        if (mRun == DC) begin
                            mPhase = 0; mE = 1'b0; mDwell = 0; mRow = (mRow + 1) % 4;
                        end
                    end else begin
                        mPhase = 2;
                    end
                end
            endcase
        end
    end

    // Compare process: DUT against model on every falling edge.
    always @(negedge CLK) begin
        if (modelValid) begin
            check4("model ROW_N", ROW_N, 4'b1111 ^ (4'b0001 << mRow));
            check4("model E", {3'b000, E}, {3'b000, mE});
            check4("model code", code, mCode);
        end
    end

    // Bounded wait for E to reach a level; counts falling edges waited.
    task automatic waitE(input logic val, input int limit, output int cyc);
        cyc = 0;
        while (E !== val && cyc < limit) begin
            @(negedge CLK);
            cyc++;
        end
        check4("wait for E", {3'b000, E}, {3'b000, val});
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        int cyc;
        RESET   = 1'b1;
        keyDown = 16'h0000;

        // 1. Reset for two edges.
        repeat (2) @(negedge CLK);
        check4("reset ROW_N", ROW_N, 4'b1110);
        check4("reset E", {3'b000, E}, 4'b0000);
        check4("reset code", code, 4'b0000);
        RESET = 1'b0;

        // 2. Idle scan: row n/4 mod 4 after n edges.
        for (int n = 0; n < 40; n++) begin
            check4("idle ROW_N", ROW_N, 4'b1111 ^ (4'b0001 << ((n / 4) % 4)));
            @(negedge CLK);
        end

        // 3. Row 2 was just entered. Press (2,1). Two synchronizer edges plus
        //    the rest of the dwell plus 8 debounce edges give 12 edges.
        keyDown[9] = 1'b1;
        waitE(1'b1, 100, cyc);
        checkInt("press latency", cyc, 12);
        check4("press code", code, 4'b1001);
        check4("press ROW_N", ROW_N, 4'b1011);
        repeat (10) begin
            @(negedge CLK);
            check4("held E", {3'b000, E}, 4'b0001);
        end

        // 5. Release bounce of 3 cycles, then re-press: E must stay high.
        keyDown[9] = 1'b0;
        repeat (3) @(negedge CLK);
        keyDown[9] = 1'b1;
        repeat (12) begin
            @(negedge CLK);
            check4("release bounce E", {3'b000, E}, 4'b0001);
        end
        // Final release: 2 synchronizer edges + 1 detect edge + 8 = 11.
        keyDown[9] = 1'b0;
        waitE(1'b0, 100, cyc);
        checkInt("release latency", cyc, 11);
        check4("release code kept", code, 4'b1001);
        check4("release ROW_N", ROW_N, 4'b0111);

        // 4. Press bounce of 3 cycles on row 2: no E, scan resumes at row 3.
        cyc = 0;
        while (ROW_N !== 4'b1011 && cyc < 40) begin
            @(negedge CLK);
            cyc++;
        end
        check4("reach row 2", ROW_N, 4'b1011);
        keyDown[9] = 1'b1;
        repeat (3) @(negedge CLK);
        keyDown[9] = 1'b0;
        repeat (3) @(negedge CLK);
        check4("bounce ROW_N", ROW_N, 4'b0111);
        check4("bounce E", {3'b000, E}, 4'b0000);

        // 6a. Keys (0,0) and (0,3) together: ambiguous, never accepted.
        keyDown[0] = 1'b1;
        keyDown[3] = 1'b1;
        repeat (40) begin
            @(negedge CLK);
            check4("two keys E", {3'b000, E}, 4'b0000);
        end
        keyDown = 16'h0000;
        repeat (8) @(negedge CLK);

        // 6b. Reset while E is high.
        keyDown[9] = 1'b1;
        waitE(1'b1, 100, cyc);
        RESET = 1'b1;
        @(negedge CLK);
        check4("reset-in-E E", {3'b000, E}, 4'b0000);
        check4("reset-in-E ROW_N", ROW_N, 4'b1110);
        check4("reset-in-E code", code, 4'b0000);
        RESET   = 1'b0;
        keyDown = 16'h0000;
        repeat (20) @(negedge CLK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
